// File: rtl/bios_fetch_ctrl.sv
// bios_fetch_ctrl: decodes CPU fetches into the BIOS window and streams block-RAM words back as single or line-fill responses.
module bios_fetch_ctrl #(
  parameter int          READ_LAT   = 1,
  parameter int          BURST_LEN  = 4,
  parameter logic [31:0] BIOS_BASE  = 32'h1FC0_0000,
  parameter int          BIOS_WORDS = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_burst,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        resp_err,
  output logic [16:0] mem_addr,
  input  logic [31:0] mem_data
);
  localparam logic [31:0] BIOS_END  = BIOS_BASE + 32'(4 * BIOS_WORDS);
  localparam logic [16:0] LINE_MASK = 17'(BURST_LEN - 1);
  localparam logic [3:0]  LAST_BEAT = 4'(BURST_LEN - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} state_t;
  state_t state_q, state_d;
  logic [3:0] beat_q, beat_d, nlast_q, nlast_d;
  logic [16:0] maddr_q, maddr_d;
  logic [READ_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
  logic rv_q, rv_d, rl_q, rl_d, re_q, re_d, rdy_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] phys;
  logic [16:0] word;
  logic legal, last, issue, tag_v;
  assign phys  = req_addr & 32'h1FFF_FFFF;
  assign word  = 17'((phys - BIOS_BASE) >> 2);
  assign legal = phys >= BIOS_BASE && phys < BIOS_END && req_addr[1:0] == 2'b00;
  assign last  = beat_q == nlast_q;
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    nlast_d = nlast_q;
    maddr_d = maddr_q;
    issue   = 1'b0;
    tag_v   = pv_q[READ_LAT-1];
    rv_d    = tag_v;
    rl_d    = tag_v & pl_q[READ_LAT-1];
    re_d    = 1'b0;
    rdata_d = tag_v ? mem_data : rdata_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        if (legal) begin
          state_d = ISSUE;
          beat_d  = '0;
          nlast_d = req_burst ? LAST_BEAT : '0;
          maddr_d = req_burst ? word & ~LINE_MASK : word;
        end else begin
          state_d = ERR;
          rv_d    = 1'b1;
          rl_d    = 1'b1;
          re_d    = 1'b1;
          rdata_d = '0;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = last ? DRAIN : ISSUE;
        beat_d  = beat_q + 4'd1;
        maddr_d = last ? maddr_q : maddr_q + 17'd1;
      end
      DRAIN: state_d = |pv_q ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
    // tags enter at bit 0 and emerge from the top after READ_LAT cycles
    pv_d = READ_LAT'({pv_q, issue});
    pl_d = READ_LAT'({pl_q, issue & last});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      nlast_q <= '0;
      maddr_q <= '0;
      pv_q    <= '0;
      pl_q    <= '0;
      rv_q    <= 1'b0;
      rl_q    <= 1'b0;
      re_q    <= 1'b0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      nlast_q <= nlast_d;
      maddr_q <= maddr_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      rv_q    <= rv_d;
      rl_q    <= rl_d;
      re_q    <= re_d;
      rdata_q <= rdata_d;
      rdy_q   <= state_d == IDLE;
    end
  end
  assign req_ready  = rdy_q & ~rst;
  assign resp_valid = rv_q;
  assign resp_last  = rl_q;
  assign resp_err   = re_q;
  assign resp_data  = rdata_q;
  assign mem_addr   = maddr_q;
endmodule
